// File: rtl/stack_sequencer_if.sv
// Opcode handshake between the instruction decoder (master) and stack_sequencer (slave).
interface stack_sequencer_if #(
  parameter int DW = 16
) ();
  logic          op_valid;
  logic          op_ready;
  logic [2:0]    op_code;
  logic [DW-1:0] op_lit;
  logic          done;
  logic [DW-1:0] result;

  modport master (
    output op_valid, op_code, op_lit,
    input  op_ready, done, result
  );

  modport slave (
    input  op_valid, op_code, op_lit,
    output op_ready, done, result
  );
endinterface

// File: rtl/stack_sequencer.sv
// Sequencer driving a 32-word top/next-window stack, one primitive per handshake.
// Define STACK_SEQ_CLEAR_EN to turn op_code 7 into CLR (pops the whole stack) instead of illegal.
module stack_sequencer #(
  parameter int DW = 16,
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst,
  stack_sequencer_if.slave op_if,
  output logic [AW-1:0]  depth,
  output logic [1:0]     err_code,
  input  logic           err_clr,
  output logic           stk_pop,
  output logic           stk_push,
  output logic           stk_w_tos,
  output logic           stk_w_next,
  output logic [DW-1:0]  stk_top_in,
  output logic [DW-1:0]  stk_next_in,
  input  logic [DW-1:0]  stk_top,
  input  logic [DW-1:0]  stk_next
);

  typedef enum logic [2:0] {
    OP_NOP, OP_LIT, OP_DROP, OP_DUP, OP_SWAP, OP_OVER, OP_ADD, OP_CLR
  } opcode_e;

`ifdef STACK_SEQ_CLEAR_EN
  typedef enum logic [2:0] {IDLE, EXEC, SETTLE, FAULT, CLRLOOP} state_e;
`else
  typedef enum logic [2:0] {IDLE, EXEC, SETTLE, FAULT} state_e;
`endif

  localparam logic [AW-1:0] DMAX = AW'(DEPTH);
  localparam logic [AW-1:0] ONE  = AW'(1);
  localparam logic [AW-1:0] TWO  = AW'(2);

  state_e        state_q, state_d;
  logic [AW-1:0] depth_q, depth_d;
  logic [1:0]    err_q, err_d;
  opcode_e       op_q, op_d;
  logic [DW-1:0] lit_q, lit_d;
  logic [1:0]    fault_code;

  assign depth    = depth_q;
  assign err_code = err_q;

  // Underflow (1) is checked before overflow (2) for ops with both bounds.
  always_comb begin
    fault_code = 2'd0;
    case (opcode_e'(op_if.op_code))
      OP_LIT:  if (depth_q >= DMAX) fault_code = 2'd2;
      OP_DROP: if (depth_q < ONE) fault_code = 2'd1;
      OP_DUP: begin
        if (depth_q < ONE) fault_code = 2'd1;
        else if (depth_q >= DMAX) fault_code = 2'd2;
      end
      OP_SWAP, OP_ADD: if (depth_q < TWO) fault_code = 2'd1;
      OP_OVER: begin
        if (depth_q < TWO) fault_code = 2'd1;
        else if (depth_q >= DMAX) fault_code = 2'd2;
      end
      OP_CLR: begin
`ifndef STACK_SEQ_CLEAR_EN
        fault_code = 2'd3;
`endif
      end
      default: fault_code = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      depth_q <= '0;
      err_q   <= '0;
      op_q    <= OP_NOP;
      lit_q   <= '0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      op_q    <= op_d;
      lit_q   <= lit_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    depth_d        = depth_q;
    op_d           = op_q;
    lit_d          = lit_q;
    err_d          = err_clr ? 2'd0 : err_q;
    op_if.op_ready = 1'b0;
    op_if.done     = 1'b0;
    op_if.result   = '0;
    stk_pop        = 1'b0;
    stk_push       = 1'b0;
    stk_w_tos      = 1'b0;
    stk_w_next     = 1'b0;
    stk_top_in     = '0;
    stk_next_in    = '0;

    case (state_q)
      IDLE: begin
        op_if.op_ready = !rst;
        if (op_if.op_valid) begin
          op_d  = opcode_e'(op_if.op_code);
          lit_d = op_if.op_lit;
          if (fault_code != 2'd0) begin
            state_d = FAULT;
            // First error wins, unless it is being cleared on this same edge.
            if (err_q == 2'd0 || err_clr) err_d = fault_code;
          end else begin
            state_d = EXEC;
          end
        end
      end

      EXEC: begin
        state_d = SETTLE;
        case (op_q)
          OP_LIT: begin
            stk_push   = 1'b1;
            stk_w_tos  = 1'b1;
            stk_top_in = lit_q;
            depth_d    = depth_q + ONE;
          end
          OP_DROP: begin
            stk_pop = 1'b1;
            depth_d = depth_q - ONE;
          end
          OP_DUP: begin
            stk_push   = 1'b1;
            stk_w_tos  = 1'b1;
            stk_top_in = stk_top;
            depth_d    = depth_q + ONE;
          end
          OP_SWAP: begin
            stk_w_tos   = 1'b1;
            stk_top_in  = stk_next;
            stk_w_next  = 1'b1;
            stk_next_in = stk_top;
          end
          OP_OVER: begin
            stk_push   = 1'b1;
            stk_w_tos  = 1'b1;
            stk_top_in = stk_next;
            depth_d    = depth_q + ONE;
          end
          OP_ADD: begin
            stk_pop    = 1'b1;
            stk_w_tos  = 1'b1;
            stk_top_in = stk_top + stk_next;
            depth_d    = depth_q - ONE;
          end
`ifdef STACK_SEQ_CLEAR_EN
          OP_CLR: if (depth_q != '0) state_d = CLRLOOP;
`endif
          default: ;
        endcase
      end

`ifdef STACK_SEQ_CLEAR_EN
      CLRLOOP: begin
        stk_pop = 1'b1;
        depth_d = depth_q - ONE;
        if (depth_q == ONE) state_d = SETTLE;
      end
`endif

      SETTLE, FAULT: begin
        op_if.done   = 1'b1;
        op_if.result = stk_top;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Self-checking bench for stack_sequencer: behavioural stack, vector table, corner sequences, random ops.
module tb_stack_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        err_clr = 1'b0;
  logic [5:0]  depth;
  logic [1:0]  err_code;
  logic        stk_pop, stk_push, stk_w_tos, stk_w_next;
  logic [15:0] stk_top_in, stk_next_in;
  logic [15:0] stk_top = 16'h0;
  logic [15:0] stk_next = 16'h0;

  int total = 0;
  int bad = 0;

  stack_sequencer_if #(.DW(16)) op_if ();

  stack_sequencer #(.DW(16), .DEPTH(32)) dut (
    .clk(clk), .rst(rst), .op_if(op_if),
    .depth(depth), .err_code(err_code), .err_clr(err_clr),
    .stk_pop(stk_pop), .stk_push(stk_push), .stk_w_tos(stk_w_tos), .stk_w_next(stk_w_next),
    .stk_top_in(stk_top_in), .stk_next_in(stk_next_in),
    .stk_top(stk_top), .stk_next(stk_next)
  );

  always #5 clk = ~clk;

  // Stack model: controls sampled mid-cycle, applied on the rising edge.
  logic [15:0] envq[$];
  logic        c_pop, c_push, c_wtos, c_wnext;
  logic [15:0] c_tin, c_nin;

  always @(negedge clk) begin
    c_pop   <= rst ? 1'b0 : stk_pop;
    c_push  <= rst ? 1'b0 : stk_push;
    c_wtos  <= rst ? 1'b0 : stk_w_tos;
    c_wnext <= rst ? 1'b0 : stk_w_next;
    c_tin   <= stk_top_in;
    c_nin   <= stk_next_in;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      envq.delete();
    end else begin
      if (c_pop && envq.size() > 0) void'(envq.pop_back());
      if (c_push) envq.push_back(16'h0);
      if (c_wtos && envq.size() > 0) envq[envq.size()-1] = c_tin;
      if (c_wnext && envq.size() > 1) envq[envq.size()-2] = c_nin;
    end
    stk_top  = (envq.size() > 0) ? envq[envq.size()-1] : 16'h0;
    stk_next = (envq.size() > 1) ? envq[envq.size()-2] : 16'h0;
  end

  int          cyc = 0;
  int          pop_cnt = 0;
  int          done_cnt = 0;
  logic [15:0] last_res;
  int          acc_log[$];

  always @(negedge clk) begin
    cyc++;
    if (stk_pop) pop_cnt++;
    if (op_if.op_valid && op_if.op_ready) acc_log.push_back(cyc);
    if (op_if.done) begin
      done_cnt++;
      last_res = op_if.result;
    end
  end

  // Reference: a plain list of values plus the sticky error code.
  logic [15:0] refq[$];
  logic [1:0]  ref_err = 2'd0;

  task automatic ref_apply(input logic [2:0] op, input logic [15:0] lit, input logic clr,
                           output int lat, output int pops, output logic chk, output logic [15:0] res);
    int d = refq.size();
    int code = 0;
    logic [15:0] a, b;
    case (op)
      3'd1: if (d >= 32) code = 2;
      3'd2: if (d < 1) code = 1;
      3'd3: if (d < 1) code = 1; else if (d >= 32) code = 2;
      3'd4, 3'd6: if (d < 2) code = 1;
      3'd5: if (d < 2) code = 1; else if (d >= 32) code = 2;
`ifndef STACK_SEQ_CLEAR_EN
      3'd7: code = 3;
`endif
      default: code = 0;
    endcase
    if (clr) ref_err = 2'd0;
    pops = 0;
    lat = 2;
    if (code != 0) begin
      if (ref_err == 2'd0) ref_err = 2'(code);
      lat = 1;
    end else begin
      case (op)
        3'd1: refq.push_back(lit);
        3'd2: begin void'(refq.pop_back()); pops = 1; end
        3'd3: refq.push_back(refq[d-1]);
        3'd4: begin a = refq[d-1]; refq[d-1] = refq[d-2]; refq[d-2] = a; end
        3'd5: refq.push_back(refq[d-2]);
        3'd6: begin a = refq.pop_back(); b = refq.pop_back(); refq.push_back(a + b); pops = 1; end
        3'd7: begin refq.delete(); pops = d; lat = d + 2; end
        default: ;
      endcase
    end
    chk = (refq.size() > 0);
    res = chk ? refq[refq.size()-1] : 16'h0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_op(input logic [2:0] op, input logic [15:0] lit, input logic clr_at_accept,
                       output logic [15:0] o_res, output logic [5:0] o_dep, output logic [1:0] o_err);
    int exp_lat, exp_pops, lat, pops0;
    logic chk, got;
    logic [15:0] exp_res;
    o_res = 16'h0; o_dep = 6'h0; o_err = 2'h0;
    ref_apply(op, lit, clr_at_accept, exp_lat, exp_pops, chk, exp_res);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk); #1;
      if (op_if.op_ready) got = 1'b1;
    end
    if (!got) begin check("ready_timeout", 0, 1); return; end
    pops0 = pop_cnt;
    op_if.op_code = op; op_if.op_lit = lit; op_if.op_valid = 1'b1; err_clr = clr_at_accept;
    @(posedge clk); #1;
    op_if.op_valid = 1'b0; err_clr = 1'b0;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (op_if.done) got = 1'b1;
    end
    if (!got) begin check("done_timeout", 0, 1); return; end
    o_res = op_if.result;
    @(posedge clk); #1;
    o_dep = depth; o_err = err_code;
    check($sformatf("op%0d_latency", op), lat, exp_lat);
    check($sformatf("op%0d_pops", op), pop_cnt - pops0, exp_pops);
    if (chk) check($sformatf("op%0d_result", op), o_res, exp_res);
    check($sformatf("op%0d_depth", op), o_dep, refq.size());
    check($sformatf("op%0d_err", op), o_err, ref_err);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    ref_err = 2'd0;
    check("err_clr", err_code, 0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] lit;
    logic        chk_res;
    logic [15:0] res;
    logic [5:0]  dep;
    logic [1:0]  err;
  } vec_t;

  vec_t vecs[18];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] r;
    logic [5:0]  dp;
    logic [1:0]  e;
    int          lat, pops, d0;
    logic        chk, got;
    logic [15:0] xr;

    vecs[0]  = '{3'd1, 16'h1234, 1'b1, 16'h1234, 6'd1, 2'd0};
    vecs[1]  = '{3'd1, 16'h0001, 1'b1, 16'h0001, 6'd2, 2'd0};
    vecs[2]  = '{3'd6, 16'h0000, 1'b1, 16'h1235, 6'd1, 2'd0};
    vecs[3]  = '{3'd2, 16'h0000, 1'b0, 16'h0000, 6'd0, 2'd0};
    vecs[4]  = '{3'd1, 16'hAAAA, 1'b1, 16'hAAAA, 6'd1, 2'd0};
    vecs[5]  = '{3'd1, 16'h5555, 1'b1, 16'h5555, 6'd2, 2'd0};
    vecs[6]  = '{3'd4, 16'h0000, 1'b1, 16'hAAAA, 6'd2, 2'd0};
    vecs[7]  = '{3'd5, 16'h0000, 1'b1, 16'h5555, 6'd3, 2'd0};
    vecs[8]  = '{3'd1, 16'hFFFF, 1'b1, 16'hFFFF, 6'd4, 2'd0};
    vecs[9]  = '{3'd1, 16'h0002, 1'b1, 16'h0002, 6'd5, 2'd0};
    vecs[10] = '{3'd6, 16'h0000, 1'b1, 16'h0001, 6'd4, 2'd0};
    vecs[11] = '{3'd3, 16'h0000, 1'b1, 16'h0001, 6'd5, 2'd0};
    vecs[12] = '{3'd0, 16'h0000, 1'b1, 16'h0001, 6'd5, 2'd0};
    vecs[13] = '{3'd2, 16'h0000, 1'b1, 16'h0001, 6'd4, 2'd0};
    vecs[14] = '{3'd2, 16'h0000, 1'b1, 16'h5555, 6'd3, 2'd0};
    vecs[15] = '{3'd2, 16'h0000, 1'b1, 16'hAAAA, 6'd2, 2'd0};
    vecs[16] = '{3'd2, 16'h0000, 1'b1, 16'h5555, 6'd1, 2'd0};
    vecs[17] = '{3'd2, 16'h0000, 1'b0, 16'h0000, 6'd0, 2'd0};

    op_if.op_valid = 1'b0; op_if.op_code = 3'd0; op_if.op_lit = 16'h0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready_held", op_if.op_ready, 0);
    rst = 1'b0;
    #1;
    check("rst_ready", op_if.op_ready, 1);
    check("rst_depth", depth, 0);
    check("rst_err", err_code, 0);
    check("rst_done", op_if.done, 0);
    check("rst_result", op_if.result, 0);
    check("rst_ctrl", {stk_pop, stk_push, stk_w_tos, stk_w_next}, 0);
    check("rst_wdata", {stk_top_in, stk_next_in}, 0);

    for (int i = 0; i < 18; i++) begin
      do_op(vecs[i].op, vecs[i].lit, 1'b0, r, dp, e);
      if (vecs[i].chk_res) check($sformatf("vec%0d_res", i), r, vecs[i].res);
      check($sformatf("vec%0d_depth", i), dp, vecs[i].dep);
      check($sformatf("vec%0d_err", i), e, vecs[i].err);
      if (i == 6) check("swap_next", stk_next, 16'h5555);
    end

    // Underflow from empty, first error sticks, then clear.
    do_op(3'd2, 16'h0, 1'b0, r, dp, e);
    check("uflow_err", e, 1);
    check("uflow_depth", dp, 0);
    do_op(3'd6, 16'h0, 1'b0, r, dp, e);
    check("uflow_sticky", e, 1);
    pulse_clr();

    // Fill to capacity, overflow, then recover.
    for (int i = 0; i < 32; i++) do_op(3'd1, 16'h0010, 1'b0, r, dp, e);
    check("full_depth", dp, 32);
    do_op(3'd3, 16'h0, 1'b0, r, dp, e);
    check("oflow_err", e, 2);
    check("oflow_depth", dp, 32);
`ifndef STACK_SEQ_CLEAR_EN
    do_op(3'd7, 16'h0, 1'b0, r, dp, e);
    check("first_err_wins", e, 2);
    do_op(3'd7, 16'h0, 1'b1, r, dp, e);
    check("clr_with_fault", e, 3);
`endif
    pulse_clr();
    do_op(3'd6, 16'h0, 1'b0, r, dp, e);
    check("recover_add_res", r, 16'h0020);
    check("recover_add_depth", dp, 31);

    // Reset during a LIT's EXEC cycle.
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (op_if.op_ready) got = 1'b1;
    end
    op_if.op_code = 3'd1; op_if.op_lit = 16'hBEEF; op_if.op_valid = 1'b1;
    @(posedge clk); #1;
    op_if.op_valid = 1'b0;
    check("midrst_push_seen", stk_push, 1);
    rst = 1'b1;
    #1;
    check("midrst_push_drop", stk_push, 0);
    check("midrst_ready", op_if.op_ready, 0);
    check("midrst_depth", depth, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    refq.delete(); ref_err = 2'd0;
    #1;
    check("midrst_ready_after", op_if.op_ready, 1);
    check("midrst_depth_after", depth, 0);

    // op_valid held high: accepts only when ready, every 3 cycles.
    acc_log.delete();
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) begin
      op_if.op_code = (i == 2) ? 3'd6 : 3'd1;
      op_if.op_lit  = (i == 0) ? 16'hFFFF : 16'h0002;
      ref_apply(op_if.op_code, op_if.op_lit, 1'b0, lat, pops, chk, xr);
      op_if.op_valid = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(posedge clk); #1;
        if (acc_log.size() > i) got = 1'b1;
      end
      if (!got) check("stream_accept_timeout", 0, 1);
    end
    op_if.op_valid = 1'b0;
    for (int k = 0; k < 20 && done_cnt < d0 + 3; k++) @(posedge clk);
    #1;
    check("stream_done_cnt", done_cnt - d0, 3);
    check("stream_add_carry", last_res, 16'h0001);
    check("stream_depth", depth, 1);
    if (acc_log.size() == 3) begin
      check("stream_gap1", acc_log[1] - acc_log[0], 3);
      check("stream_gap2", acc_log[2] - acc_log[1], 3);
    end else begin
      check("stream_accepts", acc_log.size(), 3);
    end

    // CLR from depth 5.
    for (int i = 0; i < 4; i++) do_op(3'd1, 16'(i + 7), 1'b0, r, dp, e);
    check("preclr_depth", dp, 5);
    d0 = pop_cnt;
    do_op(3'd7, 16'h0, 1'b0, r, dp, e);
`ifdef STACK_SEQ_CLEAR_EN
    check("clr_depth", dp, 0);
    check("clr_pops", pop_cnt - d0, 5);
    check("clr_err", e, 0);
`else
    check("illegal_err", e, 3);
    check("illegal_depth", dp, 5);
    check("illegal_pops", pop_cnt - d0, 0);
`endif
    pulse_clr();

    // Random ops against the reference.
    for (int i = 0; i < 80; i++) begin
      int sel = int'($urandom_range(0, 9));
      logic [2:0] op = (sel < 4) ? 3'd1 : 3'($urandom_range(0, 7));
      logic clr = ($urandom_range(0, 7) == 0);
      do_op(op, 16'($urandom()), clr, r, dp, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
